pm_resp: RTL and testbench
==========================

PM_RESP -- requirements
Module: pm_resp

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk and rst; polarity and synchronicity are fixed.
REQ-002 The block SHALL expose these parameters:
- PM_DEPTH, default 256, number of 32-bit instruction words.
- PM_AW, default 16, program-sequencer address width.
REQ-003 The block SHALL expose these ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ps_pm_cslt  in  1  PM chip select from the sequencer, active high.
- ps_pm_wrb  in  1  access type: 1 = write, 0 = read.
- ps_pm_add  in  16  word address.
- ps_pm_wdt  in  32  write data.
- pm_ps_op  out  32  instruction word returned to the sequencer.
- pm_boot_en  in  1  sampled in reset; 1 = enter BOOT after reset, 0 = enter RUN.
- ld_vld  in  1  loader word valid.
- ld_dt  in  32  loader word.
- ld_last  in  1  marks the final loader word.
- ld_rdy  out  1  loader ready.
- pm_ld_done  out  1  program load complete (level).
- pm_aerr  out  1  sticky out-of-range access flag.

Function
REQ-004 The controller SHALL have exactly two states, BOOT and RUN.
REQ-005 The load counter ld_cnt SHALL be $clog2(PM_DEPTH) bits wide.
REQ-006 In BOOT, ld_rdy SHALL be 1; each cycle with ld_vld=1 SHALL write ld_dt to mem[ld_cnt] and increment ld_cnt.
REQ-007 BOOT SHALL transition to RUN on the cycle after an accepted word with ld_last=1, or after an accepted word when ld_cnt==PM_DEPTH-1; ld_cnt SHALL never wrap.
REQ-008 In RUN, ld_rdy SHALL be 0 and ld_vld SHALL be ignored.
REQ-009 pm_ld_done SHALL equal 1 exactly while the state is RUN.
REQ-010 In BOOT, all sequencer accesses SHALL be ignored and pm_ps_op SHALL be 32'h0 (NOP).
REQ-011 Read in RUN: with cslt=1, wrb=0 and add<PM_DEPTH in cycle N, pm_ps_op SHALL equal mem[add] in cycle N+1 (1-cycle registered latency, matching the sequencer's fetch-to-decode pipeline).
REQ-012 Write in RUN: with cslt=1, wrb=1 and add<PM_DEPTH, mem[add] SHALL be written with ps_pm_wdt at the clock edge, and pm_ps_op SHALL be 32'h0 in N+1.
REQ-013 A read of the same address in the cycle after a write SHALL return the newly written data.
REQ-014 With cslt=0 in cycle N, pm_ps_op SHALL be 32'h0 in N+1.
REQ-015 Out of range (add>=PM_DEPTH, cslt=1): a read SHALL return 32'h0, a write SHALL not modify mem, and pm_aerr SHALL set in N+1 and hold until rst.
REQ-016 Address bits above $clog2(PM_DEPTH) SHALL be compared, not truncated.
REQ-017 The memory SHALL be single-port; the loader path and the sequencer path SHALL never access it in the same cycle, which the state exclusivity guarantees.

Reset
REQ-018 While rst=1:
- pm_ps_op=0, ld_cnt=0, pm_aerr=0.
- The state SHALL be BOOT if pm_boot_en=1, else RUN; ld_rdy and pm_ld_done SHALL follow the state.
REQ-019 Memory contents SHALL not be cleared by rst.
REQ-020 rst asserted mid-load SHALL abort the load; the next load SHALL restart at address 0.

Structure
REQ-021 A shared package SHALL hold the state enum (BOOT, RUN) and the constant PM_NOP=32'h0.
REQ-022 The storage SHALL be one sub-module, pm_ram: single-port, synchronous write, registered read, parameterised by depth and width.
REQ-023 The BOOT/RUN control and the loader SHALL stay in pm_resp.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Boot, last-word exit: pm_boot_en=1; load 3 words A,B,C with ld_last on C. Required: ld_rdy drops and pm_ld_done=1 the next cycle; reads of addresses 0,1,2 return A,B,C, each one cycle after its address.
- Boot, full-depth exit: load PM_DEPTH words without ld_last. Required: RUN entered after word PM_DEPTH-1; an extra ld_vld is ignored and mem[0] is unchanged.
- Write then read: in RUN, write 32'h4000_1234 to address 5, then read address 5 the next cycle. Required: pm_ps_op=32'h4000_1234 in the cycle after the read.
- Chip select low: cslt=0 for 2 cycles during reads. Required: pm_ps_op=0 for the 2 following cycles, then fetches resume.
- Out of range: read address 16'h0100 with PM_DEPTH=256. Required: pm_ps_op=0 and pm_aerr=1 the next cycle, held until rst. Write 16'hFFFF. Required: no memory word changes.
- Reset mid-load: assert rst after 2 accepted words. Required: BOOT with ld_cnt=0; a new word lands at address 0.

Source files
------------

// File: rtl/pm_resp_pkg.sv
// ---------------------------------------------------------------------------
// pm_resp_pkg
// Shared definitions for the program-memory responder: the controller state
// enum, the instruction word type and the NOP word returned whenever the
// sequencer is not being served a real fetch.
// ---------------------------------------------------------------------------
package pm_resp_pkg;

  localparam int PM_WORD_W = 32;

  typedef logic [PM_WORD_W-1:0] pm_word_t;

  // BOOT: loader owns the memory. RUN: sequencer owns the memory.
  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } pm_state_e;

  localparam pm_word_t PM_NOP = 32'h0000_0000;

endpackage : pm_resp_pkg

// File: rtl/pm_resp_if.sv
// ---------------------------------------------------------------------------
// pm_resp_if
// Sequencer <-> program-memory bus.
//   ps_pm_cslt : chip select, active high
//   ps_pm_wrb  : 1 = write, 0 = read
//   ps_pm_add  : word address (PM_AW bits)
//   ps_pm_wdt  : write data
//   pm_ps_op   : instruction word returned to the sequencer
// master = sequencer side, slave = program-memory side.
// ---------------------------------------------------------------------------
interface pm_resp_if
  import pm_resp_pkg::*;
#(
  parameter int PM_AW = 16
);

  logic             ps_pm_cslt;
  logic             ps_pm_wrb;
  logic [PM_AW-1:0] ps_pm_add;
  pm_word_t         ps_pm_wdt;
  pm_word_t         pm_ps_op;

  modport master (
    output ps_pm_cslt,
    output ps_pm_wrb,
    output ps_pm_add,
    output ps_pm_wdt,
    input  pm_ps_op
  );

  modport slave (
    input  ps_pm_cslt,
    input  ps_pm_wrb,
    input  ps_pm_add,
    input  ps_pm_wdt,
    output pm_ps_op
  );

endinterface : pm_resp_if

// File: rtl/pm_resp_ram.sv
// ---------------------------------------------------------------------------
// pm_ram
// Single-port memory: synchronous write, registered read.
//   clk   : clock
//   en    : access enable for this cycle
//   we    : 1 = write wdata to mem[addr], 0 = read mem[addr] into rdata
//   addr  : word address
//   wdata : write data
//   rdata : read data, valid the cycle after a read access; holds otherwise
// Contents are never cleared; there is no reset on the array.
// ---------------------------------------------------------------------------
module pm_ram
  import pm_resp_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int WIDTH = PM_WORD_W,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // A write does not update the read register, so a read of the same word on
  // the following cycle sees the freshly written value from the array.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata_q <= mem[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule : pm_ram

// File: rtl/pm_resp.sv
// ---------------------------------------------------------------------------
// pm_resp
// Program-memory responder. After reset it either loads a program from the
// loader stream (BOOT) or serves sequencer fetches/writes directly (RUN).
//   clk, rst    : clock, synchronous active-high reset
//   ps          : sequencer bus (slave side)
//   pm_boot_en  : sampled during reset, 1 = start in BOOT, 0 = start in RUN
//   ld_vld/ld_dt/ld_last : loader word stream, ld_rdy back-pressure
//   pm_ld_done  : high exactly while in RUN
//   pm_aerr     : sticky flag for out-of-range sequencer accesses
// ---------------------------------------------------------------------------
module pm_resp
  import pm_resp_pkg::*;
#(
  parameter int PM_DEPTH = 256,
  parameter int PM_AW    = 16
) (
  input  logic      clk,
  input  logic      rst,
  pm_resp_if.slave  ps,
  input  logic      pm_boot_en,
  input  logic      ld_vld,
  input  pm_word_t  ld_dt,
  input  logic      ld_last,
  output logic      ld_rdy,
  output logic      pm_ld_done,
  output logic      pm_aerr
);

  localparam int LD_W = (PM_DEPTH > 1) ? $clog2(PM_DEPTH) : 1;
  localparam logic [LD_W-1:0] LD_MAX = LD_W'(PM_DEPTH - 1);

  pm_state_e       state_q, state_d;
  logic [LD_W-1:0] ld_cnt_q, ld_cnt_d;
  logic            aerr_q, aerr_d;
  logic            rd_vld_q, rd_vld_d;

  logic            in_range;
  logic            ld_accept;
  logic            seq_hit;
  logic            ram_en;
  logic            ram_we;
  logic [LD_W-1:0] ram_addr;
  pm_word_t        ram_wdata;
  pm_word_t        ram_rdata;

  // The full sequencer address is compared, so a large address cannot alias
  // onto a low word by dropping its upper bits.
  always_comb begin
    in_range = ({1'b0, ps.ps_pm_add} < (PM_AW + 1)'(PM_DEPTH));
  end

  // Memory port arbitration and next-state logic. The port belongs to the
  // loader in BOOT and to the sequencer in RUN, so the two never collide.
  always_comb begin
    state_d   = state_q;
    ld_cnt_d  = ld_cnt_q;
    aerr_d    = aerr_q;
    rd_vld_d  = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = ld_cnt_q;
    ram_wdata = ld_dt;
    ld_accept = (state_q == BOOT) && ld_vld;
    seq_hit   = (state_q == RUN) && ps.ps_pm_cslt;

    if (ld_accept) begin
      ram_en = 1'b1;
      ram_we = 1'b1;
      // The counter saturates at the last word so a full load never wraps
      // back onto word 0.
      if (ld_cnt_q != LD_MAX) begin
        ld_cnt_d = ld_cnt_q + 1'b1;
      end
      if (ld_last || (ld_cnt_q == LD_MAX)) begin
        state_d = RUN;
      end
    end

    if (seq_hit) begin
      if (in_range) begin
        ram_en    = 1'b1;
        ram_we    = ps.ps_pm_wrb;
        ram_addr  = ps.ps_pm_add[LD_W-1:0];
        ram_wdata = ps.ps_pm_wdt;
        rd_vld_d  = !ps.ps_pm_wrb;
      end else begin
        aerr_d = 1'b1;
      end
    end

    // Memory contents survive reset, so nothing may be written while it is
    // asserted.
    if (rst) begin
      ram_en = 1'b0;
      ram_we = 1'b0;
    end
  end

  // Controller state, load counter, error flag and read-valid tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= pm_boot_en ? BOOT : RUN;
      ld_cnt_q <= '0;
      aerr_q   <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
      aerr_q   <= aerr_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  pm_ram #(
    .DEPTH (PM_DEPTH),
    .WIDTH (PM_WORD_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Only a valid in-range read from the previous cycle exposes RAM data;
  // every other cycle returns a NOP.
  assign ps.pm_ps_op = rd_vld_q ? ram_rdata : PM_NOP;
  assign ld_rdy      = (state_q == BOOT);
  assign pm_ld_done  = (state_q == RUN);
  assign pm_aerr     = aerr_q;

endmodule : pm_resp

// File: tb/tb_pm_resp.sv
// ---------------------------------------------------------------------------
// tb_pm_resp
// Directed scoreboard bench for pm_resp. Each driven cycle pushes the
// expected outputs for the following cycle; a negedge monitor pops and
// compares them.
// ---------------------------------------------------------------------------
module tb_pm_resp;
  import pm_resp_pkg::*;

  localparam int DEPTH = 256;

  typedef struct {
    int       due;
    pm_word_t op;
    logic     aerr;
    logic     rdy;
    logic     done;
  } exp_t;

  logic     clk = 1'b0;
  logic     rst;
  logic     pm_boot_en;
  logic     ld_vld;
  pm_word_t ld_dt;
  logic     ld_last;
  logic     ld_rdy;
  logic     pm_ld_done;
  logic     pm_aerr;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  logic m_aerr;
  logic m_rdy;
  logic m_done;

  localparam pm_word_t WA = 32'h1234_5678;
  localparam pm_word_t WB = 32'h9ABC_DEF0;
  localparam pm_word_t WC = 32'h0F0F_A5A5;

  pm_resp_if #(.PM_AW(16)) bus ();

  pm_resp #(
    .PM_DEPTH (DEPTH),
    .PM_AW    (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps         (bus),
    .pm_boot_en (pm_boot_en),
    .ld_vld     (ld_vld),
    .ld_dt      (ld_dt),
    .ld_last    (ld_last),
    .ld_rdy     (ld_rdy),
    .pm_ld_done (pm_ld_done),
    .pm_aerr    (pm_aerr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle of inputs; the expectation covers the cycle after the
  // edge that samples them.
  task automatic applyStimulus(input logic cslt, input logic wrb, input logic [15:0] add,
                               input pm_word_t wdt, input logic vld, input pm_word_t dt,
                               input logic last, input pm_word_t exp_op);
    exp_t e;
    @(posedge clk);
    #1;
    rst            = 1'b0;
    bus.ps_pm_cslt = cslt;
    bus.ps_pm_wrb  = wrb;
    bus.ps_pm_add  = add;
    bus.ps_pm_wdt  = wdt;
    ld_vld         = vld;
    ld_dt          = dt;
    ld_last        = last;
    e.due  = cyc + 1;
    e.op   = exp_op;
    e.aerr = m_aerr;
    e.rdy  = m_rdy;
    e.done = m_done;
    sb.push_back(e);
  endtask

  task automatic doReset(input logic boot);
    exp_t e;
    @(posedge clk);
    #1;
    rst            = 1'b1;
    pm_boot_en     = boot;
    bus.ps_pm_cslt = 1'b0;
    bus.ps_pm_wrb  = 1'b0;
    ld_vld         = 1'b0;
    ld_last        = 1'b0;
    m_aerr = 1'b0;
    m_rdy  = boot;
    m_done = !boot;
    e.due  = cyc + 1;
    e.op   = PM_NOP;
    e.aerr = m_aerr;
    e.rdy  = m_rdy;
    e.done = m_done;
    sb.push_back(e);
  endtask

  task automatic rd(input logic [15:0] add, input pm_word_t exp_op);
    applyStimulus(1'b1, 1'b0, add, 32'h0, 1'b0, 32'h0, 1'b0, exp_op);
  endtask

  task automatic wr(input logic [15:0] add, input pm_word_t data);
    applyStimulus(1'b1, 1'b1, add, data, 1'b0, 32'h0, 1'b0, PM_NOP);
  endtask

  task automatic ld(input pm_word_t data, input logic last);
    applyStimulus(1'b0, 1'b0, 16'h0, 32'h0, 1'b1, data, last, PM_NOP);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 32'h0, 1'b0, PM_NOP);
  endtask

  // Scoreboard monitor: compares every expectation due this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.due < cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL late_expectation due=%0d now=%0d", e.due, cyc);
      end else begin
        checkOutput("pm_ps_op", bus.pm_ps_op, e.op);
        checkOutput("pm_aerr", 32'(pm_aerr), 32'(e.aerr));
        checkOutput("ld_rdy", 32'(ld_rdy), 32'(e.rdy));
        checkOutput("pm_ld_done", 32'(pm_ld_done), 32'(e.done));
      end
    end
  end

  initial begin
    rst            = 1'b1;
    pm_boot_en     = 1'b1;
    bus.ps_pm_cslt = 1'b0;
    bus.ps_pm_wrb  = 1'b0;
    bus.ps_pm_add  = 16'h0;
    bus.ps_pm_wdt  = 32'h0;
    ld_vld         = 1'b0;
    ld_dt          = 32'h0;
    ld_last        = 1'b0;
    m_aerr = 1'b0;
    m_rdy  = 1'b1;
    m_done = 1'b0;

    $display("[TB] boot with last-word exit");
    doReset(1'b1);
    rd(16'h0000, PM_NOP);
    ld(WA, 1'b0);
    ld(WB, 1'b0);
    m_rdy  = 1'b0;
    m_done = 1'b1;
    ld(WC, 1'b1);
    rd(16'h0000, WA);
    rd(16'h0001, WB);
    rd(16'h0002, WC);
    idle();

    $display("[TB] write then read");
    wr(16'h0005, 32'h4000_1234);
    rd(16'h0005, 32'h4000_1234);
    idle();

    $display("[TB] chip select low");
    rd(16'h0000, WA);
    applyStimulus(1'b0, 1'b0, 16'h0001, 32'h0, 1'b0, 32'h0, 1'b0, PM_NOP);
    applyStimulus(1'b0, 1'b0, 16'h0001, 32'h0, 1'b0, 32'h0, 1'b0, PM_NOP);
    rd(16'h0001, WB);
    rd(16'h0002, WC);

    $display("[TB] out of range");
    wr(16'h00FF, 32'h1111_00FF);
    m_aerr = 1'b1;
    rd(16'h0100, PM_NOP);
    rd(16'h0000, WA);
    wr(16'hFFFF, 32'hDEAD_BEEF);
    wr(16'h0100, 32'hCAFE_F00D);
    rd(16'h00FF, 32'h1111_00FF);
    rd(16'h0000, WA);
    rd(16'h0005, 32'h4000_1234);
    idle();
    doReset(1'b0);
    rd(16'h0000, WA);
    rd(16'h0002, WC);

    $display("[TB] reset mid-load");
    doReset(1'b1);
    ld(32'h5555_0000, 1'b0);
    ld(32'h5555_0001, 1'b0);
    doReset(1'b1);
    @(posedge clk);
    #1;
    checkOutput("ld_cnt_after_rst", 32'(dut.ld_cnt_q), 32'h0);
    m_rdy  = 1'b0;
    m_done = 1'b1;
    ld(32'h7777_0000, 1'b1);
    rd(16'h0000, 32'h7777_0000);
    rd(16'h0001, 32'h5555_0001);
    rd(16'h0002, WC);

    $display("[TB] boot with full-depth exit");
    doReset(1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) begin
        m_rdy  = 1'b0;
        m_done = 1'b1;
      end
      ld(32'hA000_0000 + 32'(i), 1'b0);
    end
    ld(32'hBAD0_BAD0, 1'b0);
    rd(16'h0000, 32'hA000_0000);
    rd(16'h00FF, 32'hA000_00FF);
    rd(16'h0080, 32'hA000_0080);
    idle();

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(posedge clk);
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain pending=%0d expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pm_resp
